// File: rtl/rv32im_pkg.sv
// Shared RV32IM constants: M-extension funct3 encodings and the mul/div sequencer state type.
package rv32im_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> mul/div sequencer signal bundle; the pipeline drives through master, the sequencer sits on slave.
interface muldiv_sequencer_if #(parameter int XLEN = 32);

   logic            md_start;
   logic [2:0]      funct3E;
   logic [XLEN-1:0] srcA;
   logic [XLEN-1:0] srcB;
   logic            flushE;
   logic            md_stall;
   logic            md_valid;
   logic [XLEN-1:0] md_result;
   logic            md_busy;

   modport master (
      output md_start, funct3E, srcA, srcB, flushE,
      input  md_stall, md_valid, md_result, md_busy
   );

   modport slave (
      input  md_start, funct3E, srcA, srcB, flushE,
      output md_stall, md_valid, md_result, md_busy
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift the next dividend bit into the partial remainder, trial-subtract.
module div_step #(parameter int XLEN = 32) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dvs_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;
   logic          ge;

   // Remainder stays below the divisor, so one guard bit is enough for the trial subtract.
   always_comb begin
      shifted = {rem_i, quo_i[XLEN-1]};
      diff    = shifted - {1'b0, dvs_i};
      ge      = ~diff[XLEN];
      rem_o   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_o   = {quo_i[XLEN-2:0], ge};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execute unit: single-cycle multiply, 33-cycle iterative divide with pipeline stall.
// Define MULDIV_EARLY_OUT_EN to resolve divide-by-zero and signed overflow in the acceptance cycle.
module muldiv_sequencer
   import rv32im_pkg::*;
#(parameter int XLEN = 32) (
   input  logic              clk,
   input  logic              rst,
   muldiv_sequencer_if.slave md
);

   md_state_e       state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
   logic            rem_sel_q, rem_sel_d, neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d, div0_q, div0_d;

   logic [XLEN-1:0]   step_rem, step_quo;
   logic              a_sx, b_sx, div_signed;
   logic [2*XLEN-1:0] a_ext, b_ext, prod;
   logic [XLEN-1:0]   mul_res, a_mag, b_mag, quo_fix, rem_fix, div_res;
   logic              stall_c, valid_c;
   logic [XLEN-1:0]   result_c;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? -v : v;
   endfunction

   div_step #(.XLEN(XLEN)) u_div_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   // Low 2*XLEN bits of the sign/zero-extended product are exact for every signedness mix.
   always_comb begin
      a_sx       = md.srcA[XLEN-1] && (md.funct3E != F3_MULHU);
      b_sx       = md.srcB[XLEN-1] && ((md.funct3E == F3_MUL) || (md.funct3E == F3_MULH));
      a_ext      = {{XLEN{a_sx}}, md.srcA};
      b_ext      = {{XLEN{b_sx}}, md.srcB};
      prod       = a_ext * b_ext;
      mul_res    = (md.funct3E == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      div_signed = (md.funct3E == F3_DIV) || (md.funct3E == F3_REM);
      a_mag      = mag(md.srcA, div_signed);
      b_mag      = mag(md.srcB, div_signed);
      quo_fix    = neg_quo_q ? -quo_q : quo_q;
      rem_fix    = neg_rem_q ? -rem_q : rem_q;
      if (div0_q) div_res = rem_sel_q ? a_q : '1;
      else        div_res = rem_sel_q ? rem_fix : quo_fix;
   end

`ifdef MULDIV_EARLY_OUT_EN
   logic            early_div0, early_ovf, early_hit;
   logic [XLEN-1:0] early_res;

   always_comb begin
      early_div0 = (md.srcB == '0);
      early_ovf  = div_signed && (md.srcA == {1'b1, {(XLEN-1){1'b0}}}) && (&md.srcB);
      early_hit  = early_div0 || early_ovf;
      if (early_div0) early_res = md.funct3E[1] ? md.srcA : '1;
      else            early_res = md.funct3E[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      a_d       = a_q;
      rem_sel_d = rem_sel_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      stall_c   = 1'b0;
      valid_c   = 1'b0;
      result_c  = '0;
      case (state_q)
         MD_IDLE: begin
            if (md.md_start && !md.flushE) begin
               if (!md.funct3E[2]) begin
                  valid_c  = 1'b1;
                  result_c = mul_res;
               end
`ifdef MULDIV_EARLY_OUT_EN
               else if (early_hit) begin
                  valid_c  = 1'b1;
                  result_c = early_res;
               end
`endif
               else begin
                  stall_c   = 1'b1;
                  state_d   = MD_BUSY;
                  cnt_d     = '0;
                  rem_d     = '0;
                  quo_d     = a_mag;
                  dvs_d     = b_mag;
                  a_d       = md.srcA;
                  rem_sel_d = md.funct3E[1];
                  neg_quo_d = div_signed && (md.srcA[XLEN-1] ^ md.srcB[XLEN-1]);
                  neg_rem_d = div_signed && md.srcA[XLEN-1];
                  div0_d    = (md.srcB == '0);
               end
            end
         end
         MD_BUSY: begin
            stall_c = 1'b1;
            rem_d   = step_rem;
            quo_d   = step_quo;
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = MD_DONE;
               cnt_d   = '0;
            end
            if (md.flushE) begin
               state_d = MD_IDLE;
               cnt_d   = '0;
            end
         end
         MD_DONE: begin
            if (!md.flushE) begin
               valid_c  = 1'b1;
               result_c = div_res;
            end
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
      if (rst) begin
         stall_c  = 1'b0;
         valid_c  = 1'b0;
         result_c = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         a_q       <= '0;
         rem_sel_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         a_q       <= a_d;
         rem_sel_q <= rem_sel_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
      end
   end

   assign md.md_stall  = stall_c;
   assign md.md_valid  = valid_c;
   assign md.md_result = result_c;
   assign md.md_busy   = (state_q == MD_BUSY);

endmodule
